// File: rtl/spi_slave.sv
// SPI responder: oversamples an asynchronous SCK/SEL/MOSI bus with clk, receives a word
// LSB first on MOSI and returns the holding-register word MSB first on MISO.
module spi_slave #(
   parameter int unsigned DATA_BIT_WIDTH = 16,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      RST_N,
   input  logic                      SCK,
   input  logic                      SEL,
   input  logic                      MOSI,
   output logic                      MISO,
   output logic                      MISO_OE,
   input  logic [DATA_BIT_WIDTH-1:0] TX_DATA,
   input  logic                      TX_LOAD,
   output logic                      TX_PENDING,
   output logic [DATA_BIT_WIDTH-1:0] RX_DATA,
   output logic                      RX_VALID,
   output logic                      BUSY,
   output logic                      ABORT
);

   localparam int unsigned CntW = $clog2(DATA_BIT_WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_BIT_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                    state_q;
   logic [SYNC_STAGES-1:0]    sck_sync_q, sel_sync_q, mosi_sync_q;
   logic                      sck_prev_q, sel_prev_q;
   logic [DATA_BIT_WIDTH-1:0] hold_q, tx_shift_q, rx_shift_q;
   logic [CntW-1:0]           bitcnt_q;

   logic                      sck_s, sel_s, mosi_s;
   logic                      sck_rise, sck_fall, sel_rise, sel_fall;
   logic [DATA_BIT_WIDTH-1:0] tx_next, rx_next;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sel_s    = sel_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign sel_rise = sel_s & ~sel_prev_q;
   assign sel_fall = ~sel_s & sel_prev_q;

   // A load coinciding with the start of a transfer bypasses the holding register.
   assign tx_next = TX_LOAD ? TX_DATA : hold_q;
   assign rx_next = {mosi_s, rx_shift_q[DATA_BIT_WIDTH-1:1]};

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         sck_sync_q  <= '0;
         sel_sync_q  <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         sel_prev_q  <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
         sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], SEL};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         sck_prev_q  <= sck_s;
         sel_prev_q  <= sel_s;
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StIdle;
         hold_q     <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         bitcnt_q   <= '0;
         RX_DATA    <= '0;
         RX_VALID   <= 1'b0;
         ABORT      <= 1'b0;
         TX_PENDING <= 1'b0;
         MISO       <= 1'b0;
         MISO_OE    <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         RX_VALID <= 1'b0;
         ABORT    <= 1'b0;
         if (TX_LOAD) begin
            hold_q     <= TX_DATA;
            TX_PENDING <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (sel_rise) begin
                  tx_shift_q <= tx_next;
                  MISO       <= tx_next[DATA_BIT_WIDTH-1];
                  bitcnt_q   <= '0;
                  rx_shift_q <= '0;
                  TX_PENDING <= 1'b0;
                  BUSY       <= 1'b1;
                  MISO_OE    <= 1'b1;
                  state_q    <= StShift;
               end
            end
            StShift: begin
               // sel_fall outranks a simultaneous sck_rise.
               if (sel_fall) begin
                  ABORT   <= 1'b1;
                  MISO    <= 1'b0;
                  BUSY    <= 1'b0;
                  MISO_OE <= 1'b0;
                  state_q <= StIdle;
               end else if (sck_rise) begin
                  rx_shift_q <= rx_next;
                  if (bitcnt_q == LastBit) begin
                     RX_DATA  <= rx_next;
                     RX_VALID <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     bitcnt_q <= bitcnt_q + 1'b1;
                  end
               end else if (sck_fall && bitcnt_q != '0) begin
                  tx_shift_q <= tx_shift_q << 1;
                  MISO       <= tx_shift_q[DATA_BIT_WIDTH-2];
               end
            end
            StDone: begin
               if (sel_fall) begin
                  MISO    <= 1'b0;
                  BUSY    <= 1'b0;
                  MISO_OE <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: acts as the SPI master and compares against a word-level
// model of the holding register, pending flag and received data.
module tb_spi_slave;

   localparam int W    = 16;
   localparam int SYNC = 2;

   logic         clk = 1'b0;
   logic         RST_N = 1'b0;
   logic         SCK = 1'b0, SEL = 1'b0, MOSI = 1'b0, TX_LOAD = 1'b0;
   logic [W-1:0] TX_DATA = '0;
   logic         MISO, MISO_OE, TX_PENDING, RX_VALID, BUSY, ABORT;
   logic [W-1:0] RX_DATA;

   spi_slave #(.DATA_BIT_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .RST_N     (RST_N),
      .SCK       (SCK),
      .SEL       (SEL),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .MISO_OE   (MISO_OE),
      .TX_DATA   (TX_DATA),
      .TX_LOAD   (TX_LOAD),
      .TX_PENDING(TX_PENDING),
      .RX_DATA   (RX_DATA),
      .RX_VALID  (RX_VALID),
      .BUSY      (BUSY),
      .ABORT     (ABORT)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int rv_total = 0;
   int ab_total = 0;

   always @(negedge clk) begin
      if (RX_VALID) rv_total++;
      if (ABORT) ab_total++;
   end

   // Reference model state
   logic [W-1:0] m_hold = '0;
   logic [W-1:0] m_rx   = '0;
   logic         m_pend = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [W-1:0] v);
      TX_DATA = v;
      TX_LOAD = 1'b1;
      tick(1);
      TX_LOAD = 1'b0;
      m_hold = v;
      m_pend = 1'b1;
      check("pending_set", TX_PENDING, m_pend);
   endtask

   // One SEL window with `rises` SCK pulses; co=1 strobes TX_LOAD on the sel_rise cycle.
   task automatic xfer(input logic [W-1:0] mosi_w, input int rises, input int half,
                       input bit co, input logic [W-1:0] co_v);
      int           rv0, ab0;
      logic [W-1:0] exp_tx, miso_w;
      rv0 = rv_total;
      ab0 = ab_total;
      SEL  = 1'b1;
      MOSI = mosi_w[0];
      if (co) begin
         tick(SYNC);
         TX_DATA = co_v;
         TX_LOAD = 1'b1;
         tick(1);
         TX_LOAD = 1'b0;
         m_hold = co_v;
         tick(half - SYNC - 1);
      end else begin
         tick(half);
      end
      exp_tx = m_hold;
      m_pend = 1'b0;
      miso_w = '0;
      for (int i = 0; i < rises; i++) begin
         if (i < W) miso_w[W-1-i] = MISO;
         if (i == 0) begin
            check("pending_clear", TX_PENDING, 0);
            check("busy_on", BUSY, 1);
         end
         SCK = 1'b1;
         tick(half);
         SCK  = 1'b0;
         MOSI = (i + 1 < W) ? mosi_w[i+1] : ~MOSI;
         tick(half);
      end
      SEL = 1'b0;
      tick(SYNC + 2);
      check("busy_off", BUSY, 0);
      check("oe_off", MISO_OE, 0);
      tick(half);
      if (rises >= W) begin
         m_rx = mosi_w;
         check("miso_word", miso_w, exp_tx);
         check("rv_count", rv_total - rv0, 1);
         check("abort_count", ab_total - ab0, 0);
      end else begin
         check("rv_count", rv_total - rv0, 0);
         check("abort_count", ab_total - ab0, 1);
      end
      check("rx_data", RX_DATA, m_rx);
      check("pending_end", TX_PENDING, m_pend);
   endtask

   initial begin
      logic [W-1:0] w;
      int           kind, rises, half;
      bit           co;

      #1;
      check("rst_rx", RX_DATA, 0);
      check("rst_outs", {MISO, MISO_OE, TX_PENDING, RX_VALID, BUSY, ABORT}, 0);
      tick(3);
      RST_N = 1'b1;
      tick(3);

      // Basic exchange
      load(16'hA5C3);
      xfer(16'h1234, W, 8, 1'b0, '0);

      // Back-to-back: the second transfer resends the last loaded word
      load(16'h0001);
      xfer(16'hBEAD, W, 8, 1'b0, '0);
      xfer(16'h7E81, W, 6, 1'b0, '0);

      // Abort after 9 rises
      xfer(16'hFFFF, 9, 8, 1'b0, '0);

      // Overclock: 20 rises in one window
      xfer(16'hC0DE, 20, 5, 1'b0, '0);

      // Coincident load with sel_rise
      xfer(16'h5A5A, W, 8, 1'b1, 16'hBEEF);

      // Reset mid-transfer
      load(16'h3C3C);
      SEL  = 1'b1;
      MOSI = 1'b1;
      tick(8);
      for (int i = 0; i < 5; i++) begin
         SCK = 1'b1;
         tick(8);
         SCK = 1'b0;
         tick(8);
      end
      RST_N = 1'b0;
      #1;
      check("midrst_rx", RX_DATA, 0);
      check("midrst_outs", {MISO, MISO_OE, TX_PENDING, RX_VALID, BUSY, ABORT}, 0);
      SEL = 1'b0;
      tick(3);
      RST_N  = 1'b1;
      m_hold = '0;
      m_pend = 1'b0;
      m_rx   = '0;
      tick(3);
      xfer(16'h00FF, W, 8, 1'b0, '0);

      // Randomized transfers
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1) load(W'($urandom));
         kind = int'($urandom_range(0, 2));
         half = int'($urandom_range(4, 9));
         co   = ($urandom_range(0, 4) == 0);
         w    = W'($urandom);
         case (kind)
            0:       rises = W;
            1:       rises = int'($urandom_range(1, W - 1));
            default: rises = int'($urandom_range(W + 1, W + 6));
         endcase
         xfer(w, rises, half, co, W'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
